// File: rtl/arb_pkg.sv
// Shared types and sizing for the eight-way round-robin arbiter.
// Counter width tracks the timeout limit so the compare fits exactly.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int PTR_W = 3;
    localparam int TIMEOUT_CYCLES_DEF = 16;
    localparam int TO_W = $clog2(TIMEOUT_CYCLES_DEF) + 1;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    function automatic int to_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping modulo 8. Outputs one-hot winner plus its index.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] win,
    output logic [PTR_W-1:0] win_idx
);

    logic             found;
    logic [PTR_W-1:0] k;

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        k       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = ptr + PTR_W'(i);
            if (!found && req[k]) begin
                found   = 1'b1;
                win_idx = k;
            end
        end
        win = found ? (N_REQ'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant held to ack.
// Optional forced release on unacknowledged grants: ARB_TIMEOUT_EN.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             gnt_ack,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic             timeout
);

    arb_state_t       state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] pick_ptr;
    logic [N_REQ-1:0] win;
    logic [PTR_W-1:0] win_idx;
    logic             expire;
    logic             release_g;

    if (TIMEOUT_CYCLES < 2) begin : g_chk
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    // On release the search starts just past the current winner.
    assign pick_ptr  = (state == GRANT) ? gnt_idx + PTR_W'(1) : ptr;
    assign release_g = (state == GRANT) && (gnt_ack || expire);

    rr_pick8 u_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .win     (win),
        .win_idx (win_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        gnt       <= win;
                        gnt_idx   <= win_idx;
                        gnt_valid <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_g) begin
                        ptr <= gnt_idx + PTR_W'(1);
                        if (|req) begin
                            gnt     <= win;
                            gnt_idx <= win_idx;
                        end else begin
                            gnt       <= '0;
                            gnt_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = to_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;

    // Expiry on the edge that would complete the last held cycle; ack wins.
    assign expire = (state == GRANT) && !gnt_ack
                 && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= expire;
            if (state == IDLE || release_g)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_rr_arbiter8;

`ifdef ARB_TIMEOUT_EN
    localparam int TO_CYC = 4;
    localparam bit TO_EN  = 1'b1;
`else
    localparam int TO_CYC = 16;
    localparam bit TO_EN  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       gnt_ack = 1'b0;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int fails  = 0;

    // behavioural model
    bit m_busy;
    int m_idx;
    int m_p;
    int m_cnt;
    bit m_to;

    rr_arbiter8 #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt_ack   (gnt_ack),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic int first_from(input logic [7:0] r, input int p);
        for (int i = 0; i < 8; i++)
            if (r[(p + i) % 8]) return (p + i) % 8;
        return -1;
    endfunction

    task automatic model_edge(input logic rn, input logic [7:0] r,
                              input logic a);
        bit expd;
        if (!rn) begin
            m_busy = 0; m_idx = 0; m_p = 0; m_cnt = 0; m_to = 0;
        end else if (!m_busy) begin
            m_to = 0;
            if (r != 0) begin
                m_busy = 1; m_idx = first_from(r, m_p); m_cnt = 0;
            end
        end else begin
            expd = TO_EN && !a && (m_cnt == TO_CYC - 1);
            m_to = expd;
            if (a || expd) begin
                m_p = (m_idx + 1) % 8;
                m_cnt = 0;
                if (r != 0) m_idx = first_from(r, m_p);
                else m_busy = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rn, input logic [7:0] r, input logic a,
                        input string tag);
        logic [7:0] eg;
        rst_n = rn; req = r; gnt_ack = a;
        @(posedge clk);
        model_edge(rn, r, a);
        #1;
        eg = m_busy ? (8'h01 << m_idx) : 8'h00;
        chk8({tag, ".gnt"}, gnt, eg);
        chk8({tag, ".valid"}, {7'd0, gnt_valid}, {7'd0, m_busy});
        chk8({tag, ".timeout"}, {7'd0, timeout}, {7'd0, m_to});
    endtask

    initial begin
        logic [7:0] exp_seq [9];
        exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                    8'h80, 8'h01};

        // reset with all requests held
        step(0, 8'hFF, 0, "rst");
        chk8("rst_gnt", gnt, 8'h00);
        step(0, 8'hFF, 0, "rst2");
        step(1, 8'hFF, 0, "first");
        chk8("first_gnt", gnt, 8'h01);

        // full rotation with ack every cycle
        step(0, 8'h00, 0, "rst");
        for (int i = 0; i < 9; i++) begin
            step(1, 8'hFF, 1, "rot");
            chk8("rot_seq", gnt, exp_seq[i]);
        end

        // two requesters alternate
        step(0, 8'h00, 0, "rst");
        for (int i = 0; i < 4; i++) begin
            step(1, 8'h81, 1, "alt");
            chk8("alt_seq", gnt, (i % 2 == 0) ? 8'h01 : 8'h80);
        end

        // grant frozen while unacked
        step(0, 8'h00, 0, "rst");
        step(1, 8'h04, 0, "hold");
        chk8("hold_a", gnt, 8'h04);
        step(1, 8'h10, 0, "hold");
        chk8("hold_b", gnt, 8'h04);
        step(1, 8'h10, 1, "hold");
        chk8("hold_ack", gnt, 8'h10);

        // ack in idle, reset mid-grant
        step(0, 8'h00, 0, "rst");
        step(1, 8'h00, 1, "idle_ack");
        chk8("idle_ack_gnt", gnt, 8'h00);
        step(1, 8'h20, 0, "g20");
        chk8("g20", gnt, 8'h20);
        step(0, 8'h20, 0, "midrst");
        chk8("midrst_gnt", gnt, 8'h00);
        step(1, 8'hFF, 0, "postrst");
        chk8("postrst_ptr0", gnt, 8'h01);

        // unacked grant: held forever, or force-released when enabled
        step(0, 8'h00, 0, "rst");
        step(1, 8'h0A, 0, "to");
        chk8("to_first", gnt, 8'h02);
        for (int i = 0; i < 20; i++) step(1, 8'h0A, 0, "to");
        step(0, 8'h00, 0, "rst");
        step(1, 8'h0A, 0, "to2");
        for (int i = 0; i < TO_CYC - 1; i++) step(1, 8'h0A, 0, "to2");
        chk8("to2_held", gnt, 8'h02);
        step(1, 8'h0A, 0, "to2_edge");
        chk8("to2_edge_gnt", gnt, TO_EN ? 8'h08 : 8'h02);
        chk8("to2_edge_pulse", {7'd0, timeout}, {7'd0, TO_EN});
        step(1, 8'h0A, 0, "to2_after");
        chk8("to2_pulse_end", {7'd0, timeout}, 8'h00);

        // ack on expiry edge suppresses pulse
        step(0, 8'h00, 0, "rst");
        step(1, 8'h0A, 0, "ackexp");
        for (int i = 0; i < TO_CYC - 1; i++) step(1, 8'h0A, 0, "ackexp");
        step(1, 8'h0A, 1, "ackexp_edge");
        chk8("ackexp_pulse", {7'd0, timeout}, 8'h00);

        // random traffic
        step(0, 8'h00, 0, "rst");
        for (int i = 0; i < 600; i++) begin
            logic [7:0] r;
            logic a;
            logic rn;
            r  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = 8'h00;
            a  = ($urandom_range(0, 3) != 0);
            rn = ($urandom_range(0, 60) != 0);
            step(rn, r, a, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
